// File: rtl/bitwise_logic_unit_pkg.sv
// Shared definitions for the bitwise logic unit: opcodes, FSM state
// encodings and a small helper for sizing the chunk counter.
package bitwise_logic_unit_pkg;

    // Opcode encoding, also decoded by the ALU sequencer.
    typedef logic [2:0] lop_t;

    localparam lop_t LOP_NOT  = 3'b000;
    localparam lop_t LOP_AND  = 3'b001;
    localparam lop_t LOP_OR   = 3'b010;
    localparam lop_t LOP_XOR  = 3'b011;
    localparam lop_t LOP_NAND = 3'b100;
    localparam lop_t LOP_NOR  = 3'b101;
    localparam lop_t LOP_XNOR = 3'b110;
    localparam lop_t LOP_PASS = 3'b111;

    // FSM state encodings, kept as plain constants so the sequencer
    // and debug tooling can compare against the raw bus value.
    typedef logic [1:0] lu_state_t;

    localparam lu_state_t ST_IDLE = 2'b00;
    localparam lu_state_t ST_BUSY = 2'b01;
    localparam lu_state_t ST_DONE = 2'b10;

    // Chunk counter width: at least one bit even when only one chunk exists.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bitwise_logic_unit_if.sv
// Request/response bundle between the ALU sequencer (master) and the
// bitwise logic unit (slave).
//
// Handshake: a transfer happens on a rising clock edge where valid and
// ready are both high. in_ready is high only while the unit is idle;
// out_valid is high only while a finished result is held. The unit never
// takes a new request on the same edge that its result is consumed.
interface bitwise_logic_unit_if #(
    parameter int WIDTH = 32
);
    import bitwise_logic_unit_pkg::*;

    logic             in_valid;
    logic             in_ready;
    lop_t             op;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             is_zero;
    logic             busy;

    modport master (
        output in_valid, op, data_a, data_b, out_ready,
        input  in_ready, out_valid, result, is_zero, busy
    );

    modport slave (
        input  in_valid, op, data_a, data_b, out_ready,
        output in_ready, out_valid, result, is_zero, busy
    );

endinterface

// File: rtl/bitwise_logic_unit_slice.sv
// One CHUNK-wide slice of the logic unit: a purely combinational gate
// array that the top reuses for every chunk of the word.
module lu_slice
    import bitwise_logic_unit_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  lop_t             op,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic [CHUNK-1:0] y
);

    // Decode the opcode into the selected bitwise function; B is unused
    // for NOT and PASS.
    always_comb begin
        y = '0;
        case (op)
            LOP_NOT:  y = ~a;
            LOP_AND:  y = a & b;
            LOP_OR:   y = a | b;
            LOP_XOR:  y = a ^ b;
            LOP_NAND: y = ~(a & b);
            LOP_NOR:  y = ~(a | b);
            LOP_XNOR: y = ~(a ^ b);
            LOP_PASS: y = a;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Multi-cycle bitwise logic unit. Operands are captured on accept, then
// one CHUNK-wide slice of the result is produced per cycle by a single
// shared lu_slice instance. The finished word is held until consumed.
module bitwise_logic_unit
    import bitwise_logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                clock,
    input  logic                reset,
    bitwise_logic_unit_if.slave bus,
    output lu_state_t           dbg_state
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

    // The word must split into whole chunks.
    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("bitwise_logic_unit: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    lu_state_t        state;
    lop_t             op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] result_r;
    logic             is_zero_r;

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK-1:0] y_sl;
    logic [WIDTH-1:0] result_next;
    int               base;
    logic             accept;

    assign accept = bus.in_valid && (state == ST_IDLE);

    // Pick the operand slices addressed by the chunk counter and form the
    // result word as it will look after this cycle's slice write.
    always_comb begin
        base        = int'(cnt) * CHUNK;
        a_sl        = a_r[base +: CHUNK];
        b_sl        = b_r[base +: CHUNK];
        result_next = result_r;
        result_next[base +: CHUNK] = y_sl;
    end

    lu_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .op (op_r),
        .a  (a_sl),
        .b  (b_sl),
        .y  (y_sl)
    );

    // Control FSM plus operand, counter and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_r      <= '0;
            a_r       <= '0;
            b_r       <= '0;
            cnt       <= '0;
            result_r  <= '0;
            is_zero_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_r      <= bus.op;
                        a_r       <= bus.data_a;
                        b_r       <= bus.data_b;
                        cnt       <= '0;
                        result_r  <= '0;
                        is_zero_r <= 1'b0;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    result_r <= result_next;
                    if (cnt == LAST_CNT) begin
                        cnt       <= '0;
                        is_zero_r <= (result_next == '0);
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.result    = result_r;
    assign bus.is_zero   = is_zero_r && (state == ST_DONE);
    assign dbg_state     = state;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Self-checking bench for bitwise_logic_unit: a directed vector table on
// the default CHUNK=8 build, hand-written DONE-hold and mid-operation
// reset sequences, and a CHUNK=32 build driven with random operations
// checked through an expected-result queue.
module tb_bitwise_logic_unit;
    import bitwise_logic_unit_pkg::*;

    logic clock;
    logic reset;

    lu_state_t dbg8;
    lu_state_t dbg32;

    bitwise_logic_unit_if #(.WIDTH(32)) if8 ();
    bitwise_logic_unit_if #(.WIDTH(32)) if32 ();

    bitwise_logic_unit #(.WIDTH(32), .CHUNK(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (if8.slave),
        .dbg_state (dbg8)
    );

    bitwise_logic_unit #(.WIDTH(32), .CHUNK(32)) dut32 (
        .clock     (clock),
        .reset     (reset),
        .bus       (if32.slave),
        .dbg_state (dbg32)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input lop_t op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            LOP_NOT:  return ~a;
            LOP_AND:  return a & b;
            LOP_OR:   return a | b;
            LOP_XOR:  return a ^ b;
            LOP_NAND: return ~(a & b);
            LOP_NOR:  return ~(a | b);
            LOP_XNOR: return ~(a ^ b);
            default:  return a;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns just after the accepting edge.
    task automatic issue(input bit w32, input lop_t op, input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard = 0;
        while (!(w32 ? if32.in_ready : if8.in_ready) && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 20) check("in_ready_timeout", 32'd0, 32'd1);
        if (w32) begin
            if32.in_valid = 1'b1; if32.op = op; if32.data_a = a; if32.data_b = b;
        end else begin
            if8.in_valid = 1'b1; if8.op = op; if8.data_a = a; if8.data_b = b;
        end
        @(posedge clock);
        #1;
        if32.in_valid = 1'b0;
        if8.in_valid  = 1'b0;
    endtask

    // Counts rising edges after the accept until out_valid is seen;
    // returns at a falling edge.
    task automatic wait_done(input bit w32, output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (w32 ? if32.out_valid : if8.out_valid) break;
        end
        if (!(w32 ? if32.out_valid : if8.out_valid)) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    // Consume the held result; in_ready must be back one cycle later.
    task automatic take(input bit w32);
        if (w32) if32.out_ready = 1'b1; else if8.out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if32.out_ready = 1'b0;
        if8.out_ready  = 1'b0;
        check("take_in_ready", 32'(w32 ? if32.in_ready : if8.in_ready), 32'd1);
        check("take_out_valid", 32'(w32 ? if32.out_valid : if8.out_valid), 32'd0);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        string       name;
        lop_t        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int lat;
        logic [31:0] exp_r;
        lop_t rop;
        logic [31:0] ra, rb;

        vecs[0]  = '{"not",    LOP_NOT,  32'h0000_FFFF, 32'h1234_5678, 32'hFFFF_0000, 1'b0};
        vecs[1]  = '{"and",    LOP_AND,  32'hF0F0_1234, 32'h0F0F_4321, 32'h0000_0220, 1'b0};
        vecs[2]  = '{"xor",    LOP_XOR,  32'hF0F0_1234, 32'h0F0F_4321, 32'hFFFF_5115, 1'b0};
        vecs[3]  = '{"xnor",   LOP_XNOR, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0};
        vecs[4]  = '{"nor",    LOP_NOR,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[5]  = '{"or",     LOP_OR,   32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0};
        vecs[6]  = '{"nand",   LOP_NAND, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FFFF, 1'b0};
        vecs[7]  = '{"pass",   LOP_PASS, 32'hCAFE_BABE, 32'h0000_0000, 32'hCAFE_BABE, 1'b0};
        vecs[8]  = '{"not_z",  LOP_NOT,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[9]  = '{"and_z",  LOP_AND,  32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 1'b1};
        vecs[10] = '{"xor_hi", LOP_XOR,  32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0};

        if8.in_valid = 1'b0; if8.op = LOP_NOT; if8.data_a = '0; if8.data_b = '0; if8.out_ready = 1'b0;
        if32.in_valid = 1'b0; if32.op = LOP_NOT; if32.data_a = '0; if32.data_b = '0; if32.out_ready = 1'b0;

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst_in_ready",  32'(if8.in_ready), 32'd1);
        check("rst_out_valid", 32'(if8.out_valid), 32'd0);
        check("rst_busy",      32'(if8.busy), 32'd0);
        check("rst_result",    if8.result, 32'd0);
        check("rst_is_zero",   32'(if8.is_zero), 32'd0);
        check("rst_state",     32'(dbg8), 32'(ST_IDLE));
        check("rst32_in_ready", 32'(if32.in_ready), 32'd1);
        check("rst32_result",   if32.result, 32'd0);

        // Directed table on the CHUNK=8 build
        for (int i = 0; i < 11; i++) begin
            issue(1'b0, vecs[i].op, vecs[i].a, vecs[i].b);
            check({vecs[i].name, "_busy"}, 32'(if8.busy), 32'd1);
            wait_done(1'b0, lat);
            check({vecs[i].name, "_latency"}, 32'(lat), 32'd4);
            check({vecs[i].name, "_result"}, if8.result, vecs[i].res);
            check({vecs[i].name, "_is_zero"}, 32'(if8.is_zero), 32'(vecs[i].zero));
            check({vecs[i].name, "_in_ready_done"}, 32'(if8.in_ready), 32'd0);
            take(1'b0);
        end

        // Hold in DONE with in_valid high and changing inputs
        issue(1'b0, LOP_XOR, 32'h0000_000F, 32'h0000_00F0);
        wait_done(1'b0, lat);
        for (int i = 0; i < 10; i++) begin
            if8.in_valid = 1'b1;
            if8.data_a   = $urandom;
            if8.data_b   = $urandom;
            if8.op       = lop_t'($urandom_range(0, 7));
            @(posedge clock);
            @(negedge clock);
            check("hold_out_valid", 32'(if8.out_valid), 32'd1);
            check("hold_result",    if8.result, 32'h0000_00FF);
            check("hold_in_ready",  32'(if8.in_ready), 32'd0);
            check("hold_is_zero",   32'(if8.is_zero), 32'd0);
        end
        // Take with in_valid still high: must land in IDLE, not BUSY
        if8.out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if8.out_ready = 1'b0;
        if8.in_valid  = 1'b0;
        check("take_no_overlap_state", 32'(dbg8), 32'(ST_IDLE));
        check("take_hold_in_ready",    32'(if8.in_ready), 32'd1);
        check("take_hold_out_valid",   32'(if8.out_valid), 32'd0);
        @(posedge clock);
        @(negedge clock);
        check("idle_after_take", 32'(dbg8), 32'(ST_IDLE));

        // Reset two cycles into BUSY
        issue(1'b0, LOP_AND, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("mid_state",   32'(dbg8), 32'(ST_BUSY));
        check("mid_partial", if8.result, 32'h0000_FFFF);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("abort_state",     32'(dbg8), 32'(ST_IDLE));
        check("abort_out_valid", 32'(if8.out_valid), 32'd0);
        check("abort_result",    if8.result, 32'd0);
        check("abort_in_ready",  32'(if8.in_ready), 32'd1);
        check("abort_busy",      32'(if8.busy), 32'd0);
        issue(1'b0, LOP_OR, 32'd1, 32'd2);
        wait_done(1'b0, lat);
        check("post_abort_or", if8.result, 32'd3);
        check("post_abort_latency", 32'(lat), 32'd4);
        take(1'b0);

        // Random ops on the CHUNK=8 build
        for (int i = 0; i < 100; i++) begin
            rop = lop_t'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            exp_q.push_back(model(rop, ra, rb));
            issue(1'b0, rop, ra, rb);
            wait_done(1'b0, lat);
            exp_r = exp_q.pop_front();
            check("rand8_result", if8.result, exp_r);
            check("rand8_is_zero", 32'(if8.is_zero), 32'(exp_r == 32'd0));
            if8.out_ready = 1'b1;
            @(posedge clock);
            @(negedge clock);
            if8.out_ready = 1'b0;
        end

        // CHUNK=32 build: single-cycle BUSY
        issue(1'b1, LOP_PASS, 32'h8000_0001, 32'h0000_0000);
        wait_done(1'b1, lat);
        check("c32_pass_latency", 32'(lat), 32'd1);
        check("c32_pass_result",  if32.result, 32'h8000_0001);
        take(1'b1);

        for (int i = 0; i < 1000; i++) begin
            rop = lop_t'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i % 50 == 0) ? ra : $urandom;
            exp_q.push_back(model(rop, ra, rb));
            issue(1'b1, rop, ra, rb);
            wait_done(1'b1, lat);
            exp_r = exp_q.pop_front();
            check("rand32_result", if32.result, exp_r);
            if32.out_ready = 1'b1;
            @(posedge clock);
            @(negedge clock);
            if32.out_ready = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
